// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - touch gesture event codes, gesture FSM states and width helper
package touch_pkg;

    localparam logic [1:0] EVT_NONE   = 2'd0;
    localparam logic [1:0] EVT_SINGLE = 2'd1;
    localparam logic [1:0] EVT_DOUBLE = 2'd2;
    localparam logic [1:0] EVT_LONG   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS1 = 2'd1,
        ST_GAP    = 2'd2,
        ST_PRESS2 = 2'd3
    } gest_state_t;

    // Bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/touch_gesture_chan.sv
// rtl/touch_gesture_chan.sv - one touch channel: release filter, gesture FSM, event strobe
// Optional build macro TOUCH_REPEAT_EN: LONG at threshold plus auto-repeat while held.
module touch_gesture_chan
    import touch_pkg::*;
#(
    parameter int RELEASE_MS = 50,
    parameter int DTAP_MS    = 500,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       touch_i,
    output logic       evt_o,
    output logic [1:0] code_o
);

    localparam int LW = (clog2(RELEASE_MS + 1) > 0) ? clog2(RELEASE_MS + 1) : 1;
    localparam int PW = (clog2(LONG_MS + 1) > 0) ? clog2(LONG_MS + 1) : 1;
    localparam int GW = (clog2(DTAP_MS + 1) > 0) ? clog2(DTAP_MS + 1) : 1;
    localparam logic [LW-1:0] REL_MAX   = LW'(RELEASE_MS);
    localparam logic [PW-1:0] PRESS_MAX = PW'(LONG_MS);
    localparam logic [GW-1:0] GAP_MAX   = GW'(DTAP_MS);

    logic          filt_q, filt_d, filt_prev_q;
    logic [LW-1:0] lowcnt_q, lowcnt_d;
    gest_state_t   state_q;
    logic [PW-1:0] press_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic          evt_q;
    logic [1:0]    code_q;
    logic          rise, fall, press_sat;

`ifdef TOUCH_REPEAT_EN
    localparam int RW = (clog2(REPEAT_MS + 1) > 0) ? clog2(REPEAT_MS + 1) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MS - 1);
    logic [RW-1:0] rep_cnt_q;
`endif

    // A press only ends after RELEASE_MS+1 consecutive low samples.
    always_comb begin
        filt_d   = filt_q;
        lowcnt_d = lowcnt_q;
        if (touch_i) begin
            filt_d   = 1'b1;
            lowcnt_d = '0;
        end else begin
            if (lowcnt_q != REL_MAX) lowcnt_d = lowcnt_q + 1'b1;
            if (lowcnt_q >= REL_MAX) filt_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            lowcnt_q    <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            lowcnt_q    <= lowcnt_d;
        end
    end

    assign rise      = filt_q & ~filt_prev_q;
    assign fall      = ~filt_q & filt_prev_q;
    assign press_sat = (press_cnt_q >= PRESS_MAX);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            evt_q       <= 1'b0;
            code_q      <= EVT_NONE;
`ifdef TOUCH_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            evt_q  <= 1'b0;
            code_q <= EVT_NONE;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q     <= ST_PRESS1;
                        press_cnt_q <= '0;
                    end
                end
                ST_PRESS1, ST_PRESS2: begin
                    if (!press_sat) press_cnt_q <= press_cnt_q + 1'b1;
                    if (fall) begin
                        if (press_sat) begin
`ifndef TOUCH_REPEAT_EN
                            evt_q  <= 1'b1;
                            code_q <= EVT_LONG;
`endif
                            state_q <= ST_IDLE;
                        end else if (state_q == ST_PRESS1) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= '0;
                        end else begin
                            evt_q   <= 1'b1;
                            code_q  <= EVT_DOUBLE;
                            state_q <= ST_IDLE;
                        end
                    end
`ifdef TOUCH_REPEAT_EN
                    else if (press_cnt_q == PRESS_MAX - 1'b1) begin
                        evt_q     <= 1'b1;
                        code_q    <= EVT_LONG;
                        rep_cnt_q <= '0;
                    end else if (press_sat) begin
                        if (rep_cnt_q == REP_LAST) begin
                            evt_q     <= 1'b1;
                            code_q    <= EVT_LONG;
                            rep_cnt_q <= '0;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt_q != GAP_MAX) gap_cnt_q <= gap_cnt_q + 1'b1;
                    // A second press wins over the timeout landing in the same cycle.
                    if (rise) begin
                        state_q     <= ST_PRESS2;
                        press_cnt_q <= '0;
                    end else if (gap_cnt_q >= GAP_MAX) begin
                        evt_q   <= 1'b1;
                        code_q  <= EVT_SINGLE;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign evt_o  = evt_q;
    assign code_o = code_q;

endmodule

// File: rtl/touch_gesture_mux.sv
// rtl/touch_gesture_mux.sv - multi-channel touch gesture decoder with arbitrated event port
// Optional build macro TOUCH_REPEAT_EN is consumed by touch_gesture_chan.
module touch_gesture_mux
    import touch_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int RELEASE_MS = 50,
    parameter int DTAP_MS    = 500,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    localparam int CH_W      = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic            clk1k_i,
    input  logic            rstn_i,
    input  logic [N_CH-1:0] touch_in_i,
    output logic [N_CH-1:0] key_single_o,
    output logic [N_CH-1:0] key_double_o,
    output logic [N_CH-1:0] key_long_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic [1:0]      evt_code_o,
    output logic            evt_ovr_o
);

    logic [N_CH-1:0] ch_evt;
    logic [1:0]      ch_code [N_CH];
    logic [N_CH-1:0] pend_q;
    logic [1:0]      pend_code_q [N_CH];
    logic [N_CH-1:0] xfer;
    logic [CH_W-1:0] sel;
    logic            ovr_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        touch_gesture_chan #(
            .RELEASE_MS (RELEASE_MS),
            .DTAP_MS    (DTAP_MS),
            .LONG_MS    (LONG_MS),
            .REPEAT_MS  (REPEAT_MS)
        ) u_chan (
            .clk_i   (clk1k_i),
            .rstn_i  (rstn_i),
            .touch_i (touch_in_i[g]),
            .evt_o   (ch_evt[g]),
            .code_o  (ch_code[g])
        );
    end

    always_comb begin
        key_single_o = '0;
        key_double_o = '0;
        key_long_o   = '0;
        for (int i = 0; i < N_CH; i++) begin
            key_single_o[i] = ch_evt[i] && (ch_code[i] == EVT_SINGLE);
            key_double_o[i] = ch_evt[i] && (ch_code[i] == EVT_DOUBLE);
            key_long_o[i]   = ch_evt[i] && (ch_code[i] == EVT_LONG);
        end
    end

    // Fixed priority: the lowest-index pending channel is presented.
    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = CH_W'(i);
        end
    end

    assign evt_valid_o = |pend_q;
    assign evt_ch_o    = sel;
    assign evt_code_o  = evt_valid_o ? pend_code_q[sel] : EVT_NONE;
    assign evt_ovr_o   = ovr_q;

    always_comb begin
        xfer = '0;
        for (int i = 0; i < N_CH; i++) begin
            xfer[i] = evt_valid_o && evt_ready_i && (sel == CH_W'(i));
        end
    end

    // A new event always lands; it only counts as an overwrite if the old one was not leaving.
    always_ff @(posedge clk1k_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q <= '0;
            ovr_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) pend_code_q[i] <= EVT_NONE;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_evt[i]) begin
                    pend_q[i]      <= 1'b1;
                    pend_code_q[i] <= ch_code[i];
                    if (pend_q[i] && !xfer[i]) ovr_q <= 1'b1;
                end else if (xfer[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_touch_gesture_mux.sv
// tb/tb_touch_gesture_mux.sv - directed self-checking bench for touch_gesture_mux
module tb_touch_gesture_mux;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] touch = '0;
    logic         ready = 1'b0;
    logic [N-1:0] key_single, key_double, key_long;
    logic         evt_valid, evt_ovr;
    logic [1:0]   evt_ch;
    logic [1:0]   evt_code;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int cnt_s [N];
    int cnt_d [N];
    int cnt_l [N];
    int first_s [N];

    always #5 clk = ~clk;

    touch_gesture_mux #(.N_CH(N)) dut (
        .clk1k_i      (clk),
        .rstn_i       (rstn),
        .touch_in_i   (touch),
        .key_single_o (key_single),
        .key_double_o (key_double),
        .key_long_o   (key_long),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (ready),
        .evt_ch_o     (evt_ch),
        .evt_code_o   (evt_code),
        .evt_ovr_o    (evt_ovr)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            for (int c = 0; c < N; c++) begin
                if (key_single[c]) begin
                    cnt_s[c]++;
                    if (first_s[c] < 0) first_s[c] = cyc;
                end
                if (key_double[c]) cnt_d[c]++;
                if (key_long[c]) cnt_l[c]++;
            end
        end
    endtask

    task automatic clear_counts();
        cyc = 0;
        for (int c = 0; c < N; c++) begin
            cnt_s[c] = 0;
            cnt_d[c] = 0;
            cnt_l[c] = 0;
            first_s[c] = -1;
        end
    endtask

    task automatic tap(input int ch, input int hi);
        touch[ch] = 1'b1;
        tick(hi);
        touch[ch] = 1'b0;
    endtask

    task automatic ack();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        int exp_long;
        clear_counts();
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_ovr", evt_ovr, 0);
        check("rst_keys", int'({key_single, key_double, key_long}), 0);
        rstn = 1'b1;
        tick(2);

        // 1: single tap on ch0
        tap(0, 100);
        clear_counts();
        tick(600);
        check("t1_single_cnt", cnt_s[0], 1);
        check("t1_single_time", int'(first_s[0] >= 550 && first_s[0] <= 556), 1);
        check("t1_double_cnt", cnt_d[0], 0);
        check("t1_long_cnt", cnt_l[0], 0);
        check("t1_valid", evt_valid, 1);
        check("t1_ch", evt_ch, 0);
        tick(5);
        check("t1_code_held", evt_code, 1);
        ack();
        check("t1_valid_after_ack", evt_valid, 0);
        check("t1_code_after_ack", evt_code, 0);

        // 2: double tap on ch1
        clear_counts();
        tap(1, 80);
        tick(200);
        tap(1, 80);
        tick(700);
        check("t2_double_cnt", cnt_d[1], 1);
        check("t2_single_cnt", cnt_s[1], 0);
        check("t2_ch", evt_ch, 1);
        check("t2_code", evt_code, 2);
        ack();

        // 3: long press on ch2
        clear_counts();
        tap(2, 1500);
        tick(700);
`ifdef TOUCH_REPEAT_EN
        exp_long = 3;
`else
        exp_long = 1;
`endif
        check("t3_long_cnt", cnt_l[2], exp_long);
        check("t3_single_cnt", cnt_s[2] + cnt_d[2], 0);
        check("t3_ch", evt_ch, 2);
        check("t3_code", evt_code, 3);
        ack();

        // 4: short release glitch bridged by the filter
        clear_counts();
        tap(3, 30);
        tick(20);
        tap(3, 30);
        tick(700);
        check("t4_single_cnt", cnt_s[3], 1);
        check("t4_double_cnt", cnt_d[3], 0);
        check("t4_code", evt_code, 1);
        check("t4_ch", evt_ch, 3);
        ack();

        // 5: simultaneous ch0/ch2 events, arbitration and overwrite
        clear_counts();
        touch[0] = 1'b1;
        touch[2] = 1'b1;
        tick(100);
        touch[0] = 1'b0;
        touch[2] = 1'b0;
        tick(600);
        check("t5_same_cycle", int'(first_s[0] == first_s[2] && first_s[0] > 0), 1);
        check("t5_ch_first", evt_ch, 0);
        tick(10);
        check("t5_ch_stall", evt_ch, 0);
        check("t5_valid_stall", evt_valid, 1);
        ready = 1'b1;
        tick(1);
        check("t5_ch_second", evt_ch, 2);
        check("t5_code_second", evt_code, 1);
        tick(1);
        ready = 1'b0;
        check("t5_valid_drained", evt_valid, 0);
        tap(0, 100);
        tick(600);
        check("t5_ovr_before", evt_ovr, 0);
        tap(0, 100);
        tick(600);
        check("t5_ovr_after", evt_ovr, 1);
        check("t5_ovr_ch", evt_ch, 0);
        ack();

        // 6: reset in the middle of the second press
        clear_counts();
        tap(1, 80);
        tick(200);
        touch[1] = 1'b1;
        tick(40);
        rstn = 1'b0;
        tick(2);
        check("t6_valid", evt_valid, 0);
        check("t6_ovr_cleared", evt_ovr, 0);
        check("t6_keys", int'({key_single, key_double, key_long}), 0);
        touch[1] = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(700);
        check("t6_no_event", cnt_s[1] + cnt_d[1] + cnt_l[1], 0);
        check("t6_valid_idle", evt_valid, 0);
        tap(1, 80);
        tick(700);
        check("t6_next_single", cnt_s[1], 1);
        check("t6_next_ch", evt_ch, 1);
        check("t6_next_code", evt_code, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
